// File: rtl/alu_div_seq_pkg.sv
// Shared types and widths for the sequential divider next to the Alu.
package alu_div_seq_pkg;

  localparam int unsigned CPU_WORD_WIDTH = 32;
  localparam int unsigned div_word_width = CPU_WORD_WIDTH;

  // Sequencer states.
  typedef enum logic [2:0] {
    DivIdle,
    DivPrep,
    DivRun,
    DivFixup,
    DivDone
  } DivState;

  // Request and result bundles at the CPU word width.
  typedef struct packed {
    logic                      signed_op;
    logic [div_word_width-1:0] a;
    logic [div_word_width-1:0] b;
  } StrcInDiv;

  typedef struct packed {
    logic [div_word_width-1:0] quot;
    logic [div_word_width-1:0] rem;
    logic                      div_zero;
  } StrcOutDiv;

endpackage

// File: rtl/alu_div_step.sv
// One restoring-divide iteration: shifts one dividend bit into the partial
// remainder and produces one quotient bit. Purely combinational.
module alu_div_step
  import alu_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = div_word_width
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;
  logic           ge;

  // Compare/subtract at WIDTH+1 bits; the top bit of the difference is the borrow.
  always_comb begin
    r_sh = {r_i, q_i[WIDTH-1]};
    diff = r_sh - {1'b0, b_i};
    ge   = ~diff[WIDTH];
    r_o  = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    q_o  = {q_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider, one quotient bit per cycle, valid/ready on
// both sides. Define ALU_DIV_EARLY_OUT_EN to skip the iteration loop when
// |a| < |b|; results are identical either way.
module alu_div_seq
  import alu_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = div_word_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  DivState          state_q, state_d;
  logic             signed_q, signed_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div_zero_q, div_zero_d;

  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             early;
  logic [WIDTH-1:0] step_r, step_q;

  alu_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r_i(r_q),
    .q_i(q_q),
    .b_i(mag_b_q),
    .r_o(step_r),
    .q_o(step_q)
  );

  // Operand magnitudes and the optional early-out compare, from latched operands.
  always_comb begin
    sa    = signed_q & a_q[WIDTH-1];
    sb    = signed_q & b_q[WIDTH-1];
    mag_a = sa ? -a_q : a_q;
    mag_b = sb ? -b_q : b_q;
`ifdef ALU_DIV_EARLY_OUT_EN
    early = (mag_a < mag_b);
`else
    early = 1'b0;
`endif
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d    = state_q;
    signed_d   = signed_q;
    a_d        = a_q;
    b_d        = b_q;
    mag_b_d    = mag_b_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    r_d        = r_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    unique case (state_q)
      DivIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          signed_d = in_signed;
          a_d      = in_a;
          b_d      = in_b;
          state_d  = DivPrep;
        end
      end
      DivPrep: begin
        neg_q_d = sa ^ sb;
        neg_r_d = sa;
        mag_b_d = mag_b;
        if (b_q == '0) begin
          quot_d     = '1;
          rem_d      = a_q;
          div_zero_d = 1'b1;
          state_d    = DivDone;
        end else if (early) begin
          div_zero_d = 1'b0;
          q_d        = '0;
          r_d        = mag_a;
          state_d    = DivFixup;
        end else begin
          div_zero_d = 1'b0;
          r_d        = '0;
          q_d        = mag_a;
          cnt_d      = CNT_W'(WIDTH);
          state_d    = DivRun;
        end
      end
      DivRun: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DivFixup;
        end
      end
      DivFixup: begin
        quot_d  = neg_q_q ? -q_q : q_q;
        rem_d   = neg_r_q ? -r_q : r_q;
        state_d = DivDone;
      end
      DivDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = DivIdle;
        end
      end
      default: state_d = DivIdle;
    endcase
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivIdle;
      signed_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      mag_b_q    <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      r_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      signed_q   <= signed_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mag_b_q    <= mag_b_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      r_q        <= r_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign out_quot     = quot_q;
  assign out_rem      = rem_q;
  assign out_div_zero = div_zero_q;

endmodule
